// File: rtl/rule_match_unit.sv
// Five-tuple range comparator: one packet header against one rule box, combinational and registered results.
// Optional feature macro: RULE_MATCH_HIT_COUNT_EN adds clear_count input and a saturating hit_count output.
module rule_match_unit #(
  parameter int IP_W    = 32,
  parameter int PORT_W  = 16,
  parameter int PROTO_W = 8
) (
  input  logic               clk,
  input  logic               reset,
`ifdef RULE_MATCH_HIT_COUNT_EN
  input  logic               clear_count,
  output logic [31:0]        hit_count,
`endif
  input  logic               in_valid,
  input  logic [IP_W-1:0]    rule_start_src_ip,
  input  logic [IP_W-1:0]    rule_start_dst_ip,
  input  logic [PORT_W-1:0]  rule_start_src_port,
  input  logic [PORT_W-1:0]  rule_start_dst_port,
  input  logic [PROTO_W-1:0] rule_start_protocol,
  input  logic [IP_W:0]      rule_last_src_ip,
  input  logic [IP_W:0]      rule_last_dst_ip,
  input  logic [PORT_W:0]    rule_last_src_port,
  input  logic [PORT_W:0]    rule_last_dst_port,
  input  logic [PROTO_W:0]   rule_last_protocol,
  input  logic [IP_W-1:0]    pkt_src_ip,
  input  logic [IP_W-1:0]    pkt_dst_ip,
  input  logic [PORT_W-1:0]  pkt_src_port,
  input  logic [PORT_W-1:0]  pkt_dst_port,
  input  logic [PROTO_W-1:0] pkt_protocol,
  output logic               matched_comb,
  output logic [4:0]         field_match,
  output logic               matched,
  output logic               out_valid
);

  // The upper bound is one bit wider so 2^W can express "up to and including the field maximum".
  assign field_match[0] = (pkt_src_ip   >= rule_start_src_ip)   && ({1'b0, pkt_src_ip}   < rule_last_src_ip);
  assign field_match[1] = (pkt_dst_ip   >= rule_start_dst_ip)   && ({1'b0, pkt_dst_ip}   < rule_last_dst_ip);
  assign field_match[2] = (pkt_src_port >= rule_start_src_port) && ({1'b0, pkt_src_port} < rule_last_src_port);
  assign field_match[3] = (pkt_dst_port >= rule_start_dst_port) && ({1'b0, pkt_dst_port} < rule_last_dst_port);
  assign field_match[4] = (pkt_protocol >= rule_start_protocol) && ({1'b0, pkt_protocol} < rule_last_protocol);

  assign matched_comb = &field_match;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      matched   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      matched   <= in_valid & matched_comb;
    end
  end

`ifdef RULE_MATCH_HIT_COUNT_EN
  // Saturating counter; clear wins over a same-cycle hit.
  always_ff @(posedge clk) begin
    if (reset || clear_count) begin
      hit_count <= '0;
    end else if (in_valid && matched_comb && (hit_count != 32'hFFFF_FFFF)) begin
      hit_count <= hit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rule_match_unit.sv
// Self-checking bench for rule_match_unit: range-box model plus hand-computed directed vectors.
// Define RULE_MATCH_HIT_COUNT_EN when compiling to also exercise the hit counter.
module tb_rule_match_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] rs_src_ip, rs_dst_ip;
  logic [15:0] rs_src_port, rs_dst_port;
  logic [7:0]  rs_protocol;
  logic [32:0] rl_src_ip, rl_dst_ip;
  logic [16:0] rl_src_port, rl_dst_port;
  logic [8:0]  rl_protocol;
  logic [31:0] pkt_src_ip, pkt_dst_ip;
  logic [15:0] pkt_src_port, pkt_dst_port;
  logic [7:0]  pkt_protocol;
  logic        matched_comb, matched, out_valid;
  logic [4:0]  field_match;
`ifdef RULE_MATCH_HIT_COUNT_EN
  logic        clear_count;
  logic [31:0] hit_count;
  longint      exp_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit exp_ov, exp_m;

  always #5 clk = ~clk;

  rule_match_unit dut (
    .clk                 (clk),
    .reset               (reset),
`ifdef RULE_MATCH_HIT_COUNT_EN
    .clear_count         (clear_count),
    .hit_count           (hit_count),
`endif
    .in_valid            (in_valid),
    .rule_start_src_ip   (rs_src_ip),
    .rule_start_dst_ip   (rs_dst_ip),
    .rule_start_src_port (rs_src_port),
    .rule_start_dst_port (rs_dst_port),
    .rule_start_protocol (rs_protocol),
    .rule_last_src_ip    (rl_src_ip),
    .rule_last_dst_ip    (rl_dst_ip),
    .rule_last_src_port  (rl_src_port),
    .rule_last_dst_port  (rl_dst_port),
    .rule_last_protocol  (rl_protocol),
    .pkt_src_ip          (pkt_src_ip),
    .pkt_dst_ip          (pkt_dst_ip),
    .pkt_src_port        (pkt_src_port),
    .pkt_dst_port        (pkt_dst_port),
    .pkt_protocol        (pkt_protocol),
    .matched_comb        (matched_comb),
    .field_match         (field_match),
    .matched             (matched),
    .out_valid           (out_valid)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a field hits when its value lies in the half-open interval [start, last).
  function automatic bit in_range(input longint s, input longint p, input longint l);
    return (s <= p) && (p < l);
  endfunction

  function automatic logic [4:0] model_fm();
    logic [4:0] fm;
    fm[0] = in_range(rs_src_ip,   pkt_src_ip,   rl_src_ip);
    fm[1] = in_range(rs_dst_ip,   pkt_dst_ip,   rl_dst_ip);
    fm[2] = in_range(rs_src_port, pkt_src_port, rl_src_port);
    fm[3] = in_range(rs_dst_port, pkt_dst_port, rl_dst_port);
    fm[4] = in_range(rs_protocol, pkt_protocol, rl_protocol);
    return fm;
  endfunction

  function automatic bit model_hit();
    return model_fm() == 5'b11111;
  endfunction

  // Expected registered state, built from the inputs the DUT sees at each rising edge.
  always @(posedge clk) begin
    exp_ov = !reset && in_valid;
    exp_m  = !reset && in_valid && model_hit();
`ifdef RULE_MATCH_HIT_COUNT_EN
    if (reset || clear_count) exp_cnt = 0;
    else if (in_valid && model_hit() && exp_cnt < 64'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model field_match", {59'd0, field_match}, {59'd0, model_fm()});
      check("model matched_comb", {63'd0, matched_comb}, {63'd0, model_hit()});
      check("model out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      check("model matched", {63'd0, matched}, {63'd0, exp_m});
`ifdef RULE_MATCH_HIT_COUNT_EN
      check("model hit_count", {32'd0, hit_count}, exp_cnt);
`endif
    end
  end

  task automatic set_full();
    rs_src_ip = '0;   rl_src_ip = 33'h1_0000_0000;
    rs_dst_ip = '0;   rl_dst_ip = 33'h1_0000_0000;
    rs_src_port = '0; rl_src_port = 17'h1_0000;
    rs_dst_port = '0; rl_dst_port = 17'h1_0000;
    rs_protocol = '0; rl_protocol = 9'h100;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    set_full();
    pkt_src_ip = '0; pkt_dst_ip = '0; pkt_src_port = '0; pkt_dst_port = '0; pkt_protocol = '0;
`ifdef RULE_MATCH_HIT_COUNT_EN
    clear_count = 1'b0;
`endif
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    @(negedge clk);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset matched", {63'd0, matched}, 64'd0);

    // src_ip box [10.0.0.0, 10.0.1.0), others full; packet 10.0.0.5
    next_cycle();
    reset = 1'b0;
    rs_src_ip = 32'h0A00_0000; rl_src_ip = 33'h0_0A00_0100;
    pkt_src_ip = 32'h0A00_0005; pkt_dst_ip = 32'hC0A8_0101;
    pkt_src_port = 16'd1234; pkt_dst_port = 16'd443; pkt_protocol = 8'd6;
    in_valid = 1'b1;
    @(negedge clk);
    check("t1 matched_comb", {63'd0, matched_comb}, 64'd1);
    check("t1 field_match", {59'd0, field_match}, 64'h1F);

    // Packet on the exclusive bound
    next_cycle();
    pkt_src_ip = 32'h0A00_0100;
    @(negedge clk);
    check("t1 reg matched", {63'd0, matched}, 64'd1);
    check("t1 reg out_valid", {63'd0, out_valid}, 64'd1);
    check("t2 field_match", {59'd0, field_match}, 64'h1E);
    check("t2 matched_comb", {63'd0, matched_comb}, 64'd0);

    // dst_port [80, 81): 80 hits, 79 misses; protocol 0xFF under last 0x100
    next_cycle();
    set_full();
    rs_dst_port = 16'd80; rl_dst_port = 17'd81;
    pkt_dst_port = 16'd80; pkt_protocol = 8'hFF;
    @(negedge clk);
    check("t2 reg matched", {63'd0, matched}, 64'd0);
    check("t2 reg out_valid", {63'd0, out_valid}, 64'd1);
    check("dport 80 hit", {63'd0, matched_comb}, 64'd1);
    check("proto FF hit", {63'd0, field_match[4]}, 64'd1);
    next_cycle();
    pkt_dst_port = 16'd79;
    @(negedge clk);
    check("dport 79 miss", {59'd0, field_match}, 64'h17);

    // Empty and inverted protocol ranges
    next_cycle();
    pkt_dst_port = 16'd80;
    rs_protocol = 8'd6; rl_protocol = 9'd6; pkt_protocol = 8'd6;
    @(negedge clk);
    check("empty proto", {63'd0, matched_comb}, 64'd0);
    next_cycle();
    rs_protocol = 8'd9; rl_protocol = 9'd7; pkt_protocol = 8'd8;
    @(negedge clk);
    check("inverted proto", {63'd0, matched_comb}, 64'd0);

    // Boundary values at both extremes with full ranges
    next_cycle();
    set_full();
    pkt_src_ip = 32'hFFFF_FFFF; pkt_dst_ip = 32'h0; pkt_src_port = 16'hFFFF;
    pkt_dst_port = 16'h0; pkt_protocol = 8'hFF;
    @(negedge clk);
    check("full range extremes", {63'd0, matched_comb}, 64'd1);

    // Stream hit, miss, hit(reset), hit
    next_cycle();
    rs_src_port = 16'd100; rl_src_port = 17'd200;
    pkt_src_port = 16'd150; in_valid = 1'b1;
    next_cycle();
    pkt_src_port = 16'd200;
    @(negedge clk);
    check("stream 1 out", {62'd0, out_valid, matched}, 64'b11);
    next_cycle();
    pkt_src_port = 16'd100; reset = 1'b1;
    @(negedge clk);
    check("stream 2 out", {62'd0, out_valid, matched}, 64'b10);
    next_cycle();
    pkt_src_port = 16'd199; reset = 1'b0;
    @(negedge clk);
    check("stream reset out", {62'd0, out_valid, matched}, 64'b00);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("stream resume out", {62'd0, out_valid, matched}, 64'b11);
    next_cycle();
    @(negedge clk);
    check("idle out", {62'd0, out_valid, matched}, 64'b00);

`ifdef RULE_MATCH_HIT_COUNT_EN
    next_cycle();
    clear_count = 1'b1;
    next_cycle();
    clear_count = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      pkt_src_port = (i == 3) ? 16'd50 : 16'd150;
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("hit_count 3", {32'd0, hit_count}, 64'd3);
    next_cycle();
    in_valid = 1'b1; clear_count = 1'b1;
    next_cycle();
    in_valid = 1'b0; clear_count = 1'b0;
    @(negedge clk);
    check("hit_count clear", {32'd0, hit_count}, 64'd0);
`endif

    next_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rule_match_unit.md
Name: rule_match_unit

Overview:
- Five-tuple range comparator for the NeuroCuts packet classifier.
- Tests one packet header against one rule/range box: {src_ip, dst_ip, src_port, dst_port, protocol}.
- Each field range is inclusive start, exclusive last.
- Used per rule slot in leaf matching and per child in cut matching. Provides a combinational result and a one-cycle registered result with valid.

Parameters:
IP_W, 32, IP address field width
PORT_W, 16, port field width
PROTO_W, 8, protocol field width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  qualifies packet/rule inputs this cycle
rule_start_src_ip  in  IP_W  inclusive lower bound, source IP
rule_start_dst_ip  in  IP_W  inclusive lower bound, destination IP
rule_start_src_port  in  PORT_W  inclusive lower bound, source port
rule_start_dst_port  in  PORT_W  inclusive lower bound, destination port
rule_start_protocol  in  PROTO_W  inclusive lower bound, protocol
rule_last_src_ip  in  IP_W+1  exclusive upper bound, source IP
rule_last_dst_ip  in  IP_W+1  exclusive upper bound, destination IP
rule_last_src_port  in  PORT_W+1  exclusive upper bound, source port
rule_last_dst_port  in  PORT_W+1  exclusive upper bound, destination port
rule_last_protocol  in  PROTO_W+1  exclusive upper bound, protocol
pkt_src_ip  in  IP_W  packet source IP
pkt_dst_ip  in  IP_W  packet destination IP
pkt_src_port  in  PORT_W  packet source port
pkt_dst_port  in  PORT_W  packet destination port
pkt_protocol  in  PROTO_W  packet protocol
matched_comb  out  1  combinational match of current inputs
field_match  out  5  combinational per-field hits {proto,dst_port,src_port,dst_ip,src_ip} (bit0 = src_ip)
matched  out  1  registered match, valid when out_valid
out_valid  out  1  registered copy of in_valid

Behaviour:
- Field hit requires start <= pkt AND pkt < last, both unsigned.
- Compare pkt zero-extended to W+1 bits against last. An upper bound of 2^W (MSB set, rest 0) therefore covers the field maximum.
- matched_comb is the AND of all five field_match bits. It is purely combinational, has no dependence on in_valid or reset, and has zero latency.
- Empty range (start >= last) in any field: that field never hits, so matched_comb = 0.
- Full range (start = 0, last = 2^W) in every field matches any packet.
- Exact bounds:
  - pkt == start hits.
  - pkt == last-1 hits.
  - pkt == last misses.
- Register stage, on every posedge clk:
  - out_valid <= in_valid.
  - matched <= in_valid & matched_comb.
  - Latency is 1 cycle. Back-to-back in_valid every cycle is supported with no stall and no ready signal.
- Reset (synchronous, priority over everything): out_valid = 0, matched = 0. Reset asserted mid-stream drops the in-flight result. The first valid result appears 1 cycle after the first in_valid sampled with reset low.
- When out_valid = 0, matched is 0.

Optional Feature:
- RULE_MATCH_HIT_COUNT_EN defined adds two ports:
  - hit_count out 32, count of cycles where in_valid & matched_comb. Reset to 0, increments by 1, saturates at 32'hFFFF_FFFF (no wrap).
  - clear_count in 1, synchronous clear to 0. Clear takes priority over increment.
- Undefined: neither port exists and no counter logic is present. All other behaviour is identical.

Test Plan:
- Rule src_ip [10.0.0.0, 10.0.1.0), other fields full range; pkt src_ip 10.0.0.5, in_valid = 1 -> matched_comb = 1, field_match = 5'b11111, next cycle matched = 1, out_valid = 1.
- Same rule, pkt src_ip 10.0.1.0 (== last) -> field_match[0] = 0, matched_comb = 0, next cycle matched = 0, out_valid = 1.
- dst_port range [80, 81), pkt dst_port 80 -> hit; pkt dst_port 79 -> miss. Protocol last = 9'h100, pkt protocol 8'hFF -> hit.
- Empty range protocol start = 6, last = 6 with all other fields matching -> matched_comb = 0.
- Stream in_valid for 4 cycles alternating hit/miss, assert reset on the 3rd cycle -> outputs 1, 0, then out_valid = 0, matched = 0 during reset, resuming 1 cycle after reset drops.
- With RULE_MATCH_HIT_COUNT_EN defined: 3 valid hits + 1 valid miss + 2 invalid hits -> hit_count = 3. Then clear_count = 1 together with a hit -> hit_count = 0.
